// File: rtl/dma_command_sequencer.sv
// Descriptor queue that feeds the stream-to-AXI adapter control port one transfer at a time.
// Optional retired-descriptor counter: define DMA_COMMAND_SEQUENCER_COMPLETION_COUNTER_EN.
//
//   state | meaning
//   IDLE  | waiting for a queued descriptor and an idle adapter (tdone high)
//   ISSUE | tstart follows tdone until the adapter reports busy
//   WAIT  | adapter busy with the active descriptor; retire when tdone returns
module dma_command_sequencer #(
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                    aclk,
   input  logic                    resetn,
   input  logic                    s_cmd_valid,
   output logic                    s_cmd_ready,
   input  logic [ADDR_WIDTH-1:0]   s_cmd_addr,
   input  logic [ADDR_WIDTH-1:0]   s_cmd_bytes,
   input  logic                    s_cmd_axilast,
   output logic                    tstart,
   output logic [ADDR_WIDTH-1:0]   taddr,
   output logic [ADDR_WIDTH-1:0]   tbytes,
   output logic                    enableAxiLastSignal,
   input  logic                    tdone,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  cmd_count,
   output logic                    done_pulse
`ifdef DMA_COMMAND_SEQUENCER_COMPLETION_COUNTER_EN
   ,
   output logic [15:0]             completed_count
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   q_addr  [DEPTH];
   logic [ADDR_WIDTH-1:0]   q_bytes [DEPTH];
   logic                    q_last  [DEPTH];
   logic [PTR_W-1:0]        wr_ptr, rd_ptr;
   logic                    push, pop, retire;

   assign s_cmd_ready = (cmd_count != FULL_CNT);
   assign push        = s_cmd_valid && s_cmd_ready;
   assign busy        = (state != IDLE) || (cmd_count != '0);

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      retire    = 1'b0;
      tstart    = 1'b0;
      case (state)
         IDLE: begin
            if ((cmd_count != '0) && tdone) begin
               pop = 1'b1;
               // zero-length descriptors retire without ever touching the adapter
               if (q_bytes[rd_ptr] == '0) retire = 1'b1;
               else                       state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            tstart = tdone;
            if (!tdone) state_nxt = WAIT;
         end
         WAIT: begin
            if (tdone) begin
               retire    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (push) begin
         q_addr[wr_ptr]  <= s_cmd_addr;
         q_bytes[wr_ptr] <= s_cmd_bytes;
         q_last[wr_ptr]  <= s_cmd_axilast;
      end
   end

   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         state               <= IDLE;
         wr_ptr              <= '0;
         rd_ptr              <= '0;
         cmd_count           <= '0;
         taddr               <= '0;
         tbytes              <= '0;
         enableAxiLastSignal <= 1'b0;
         done_pulse          <= 1'b0;
      end else begin
         state      <= state_nxt;
         done_pulse <= retire;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) begin
            rd_ptr              <= rd_ptr + PTR_W'(1);
            taddr               <= q_addr[rd_ptr];
            tbytes              <= q_bytes[rd_ptr];
            enableAxiLastSignal <= q_last[rd_ptr];
         end
         case ({push, pop})
            2'b10:   cmd_count <= cmd_count + CNT_W'(1);
            2'b01:   cmd_count <= cmd_count - CNT_W'(1);
            default: cmd_count <= cmd_count;
         endcase
      end
   end

`ifdef DMA_COMMAND_SEQUENCER_COMPLETION_COUNTER_EN
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn)         completed_count <= '0;
      else if (done_pulse) completed_count <= completed_count + 16'd1;
   end
`endif

endmodule

// File: doc/dma_command_sequencer.md
# dma_command_sequencer

Queues DMA descriptors (address, byte count, last-signal mode) and issues them one at a time to the AXI-stream-to-AXI adapter stage through its `tstart`/`taddr`/`tbytes`/`tdone` control port. It sits directly upstream of that adapter's control port. Typical sources are the command parser and the framebuffer/texture streaming logic. Software can therefore post several transfers back-to-back without polling `tdone` between them.

## Interface
- `ADDR_WIDTH`, 32, width of address and byte-count fields
- `DEPTH`, 4, descriptor queue entries; power of two, ≥ 2
- `aclk`  in  1  clock
- `resetn`  in  1  asynchronous, active-low reset
- `s_cmd_valid`  in  1  descriptor offered
- `s_cmd_ready`  out  1  queue not full
- `s_cmd_addr`  in  ADDR_WIDTH  start address
- `s_cmd_bytes`  in  ADDR_WIDTH  transfer size in bytes
- `s_cmd_axilast`  in  1  value forwarded to `enableAxiLastSignal`
- `tstart`  out  1  start request to adapter
- `taddr`  out  ADDR_WIDTH  address of the active descriptor
- `tbytes`  out  ADDR_WIDTH  size of the active descriptor
- `enableAxiLastSignal`  out  1  last-signal mode of the active descriptor
- `tdone`  in  1  adapter idle (high) / busy (low)
- `busy`  out  1  state ≠ IDLE, or queue not empty
- `cmd_count`  out  $clog2(DEPTH)+1  descriptors currently queued
- `done_pulse`  out  1  one-cycle pulse per retired descriptor
- `completed_count`  out  16  retired-descriptor counter (only with macro)

## Operation
- Queue is a circular buffer with wrapping read/write pointers and a count register.
  - Push when `s_cmd_valid && s_cmd_ready`.
  - `s_cmd_ready = (cmd_count != DEPTH)`.
  - Simultaneous push and pop leave `cmd_count` unchanged.
  - A push into a full queue is impossible because `s_cmd_ready` is low.
- FSM states: IDLE, ISSUE, WAIT.
  - **IDLE:** if queue non-empty and `tdone == 1`, pop the head into `taddr`/`tbytes`/`enableAxiLastSignal` registers.
    - If the popped bytes are 0: drop the descriptor, assert `done_pulse`, stay in IDLE. No `tstart` is generated.
    - Otherwise go to ISSUE.
  - **ISSUE:** `tstart = tdone` (combinational from the state register and the `tdone` input). When `tdone == 0` is sampled, go to WAIT.
  - **WAIT:** `tstart = 0`. When `tdone == 1` is sampled, assert `done_pulse` for one cycle and go to IDLE.
- `taddr`, `tbytes` and `enableAxiLastSignal` stay stable from the pop until the next pop.
- The sequencer never issues while `tdone` is low. Any adapter activity owned by another master delays the pop.

## Timing
- Reset values: `s_cmd_ready` 1, `tstart` 0, `taddr` 0, `tbytes` 0, `enableAxiLastSignal` 0, `busy` 0, `cmd_count` 0, `done_pulse` 0, `completed_count` 0; pointers 0; state IDLE.
- Reset asserted mid-transfer: the queue is flushed and the FSM returns to IDLE immediately. The adapter is reset by the same `resetn`.
- Issue latency, with the queue empty and `tdone` high:
  - Push accepted on edge E0.
  - Pop on edge E1.
  - `tstart` high in the cycle after E1.
- `tstart` falls combinationally in the cycle `tdone` is low. The adapter therefore never sees `tstart` while busy.
- `done_pulse` is high in the cycle after `tdone` is sampled high in WAIT. The next descriptor is popped in that same cycle if available.
- Minimum descriptor spacing: 1 IDLE cycle plus the adapter's busy time.
- Zero-byte descriptors retire one per cycle while in IDLE.

## Configuration
- Macro: `DMA_COMMAND_SEQUENCER_COMPLETION_COUNTER_EN`.
- **Defined:** `completed_count` increments by 1 on every `done_pulse`, including dropped zero-byte descriptors. It wraps from 0xFFFF to 0 and resets to 0.
- **Undefined:** the port is absent and no counter logic is built.

## Test plan
- **Single descriptor:** push (0x1000, 64, 1); adapter model drops `tdone` 1 cycle after `tstart`, raises it 20 cycles later.
  - Expect: `taddr` = 0x1000, `tbytes` = 64, `enableAxiLastSignal` = 1.
  - Expect: `tstart` high for exactly one cycle, then one `done_pulse`; `busy` falls afterward.
- **Fill queue (DEPTH=4):** push 5 descriptors while the adapter holds `tdone` low.
  - Expect: `s_cmd_ready` low after 4 pushes, `cmd_count` = 4.
  - Expect: 5th accepted only after the first pop; issue order matches push order.
- **Simultaneous push and pop at `cmd_count` = 2:** expect `cmd_count` stays 2 and pointers wrap correctly after 8 total descriptors.
- **Zero-byte descriptor:** push (0x2000, 0, 0) then (0x3000, 16, 0).
  - Expect: `done_pulse` for the first with no `tstart`.
  - Expect: the second is issued the next cycle.
- **Externally busy adapter:** `tdone` held low at push time. Expect no pop and `tstart` stays 0 until `tdone` rises.
- **Reset mid-WAIT with 3 queued:** assert `resetn` low asynchronously.
  - Expect all outputs at reset values immediately and `cmd_count` = 0.
  - With the macro defined, expect `completed_count` = 0.
